// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the MAC datapath.
//
// Accepts a start command with a vector length, pulls 4-bit operand pairs over
// a valid/ready stream, drives each pair into the external mul4 multiplier via
// registered operands, and accumulates the 8-bit product into an ACC_W-bit
// accumulator. Pulses done for one cycle when the final sum is on result.
//
// Optional build macro: MAC_SATURATE_EN
//   defined   -> accumulator clamps to all-ones on carry-out (sticky for the vector)
//   undefined -> accumulator wraps modulo 2^ACC_W
//   ovf is set on carry-out in both builds.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     begin a new dot product (sampled in IDLE only)
//   len       number of operand pairs (sampled with start)
//   in_valid  operand pair on a/b valid
//   in_ready  controller accepts a pair this cycle (RUN state)
//   a, b      4-bit operands
//   mul_a     registered operand to mul4 input a
//   mul_b     registered operand to mul4 input b
//   mul_p     8-bit product from mul4 (combinational from mul_a/mul_b)
//   busy      high in every state except IDLE
//   done      one-cycle pulse when result is final
//   result    accumulator value
//   ovf       sticky overflow flag for the current vector
//
// State | meaning
// IDLE  | waiting for start
// RUN   | waiting for an operand pair handshake
// ACC   | product of the captured pair is added into the accumulator
// DONE  | result final, done pulses for this one cycle
module mac_seq_ctrl #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W:0]   sum;

    // One extra bit so the carry-out is visible for the overflow flag.
    assign sum    = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, mul_p};
    assign result = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = (remaining == LEN_W'(1)) ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        mul_a <= a;
                        mul_b <= b;
                    end
                end
                ACC: begin
                    remaining <= remaining - LEN_W'(1);
                    if (sum[ACC_W]) begin
                        ovf <= 1'b1;
`ifdef MAC_SATURATE_EN
                        acc <= '1;
`else
                        acc <= sum[ACC_W-1:0];
`endif
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    localparam int ACC_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_p;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
    logic             ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int res;
        int ovf;
        int cyc;   // expected absolute done cycle, -1 = not checked
        string name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mul4 behavioural model
    assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

    mac_seq_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, int'(result), e.res);
                check({e.name, "_ovf"}, int'(ovf), e.ovf);
                if (e.cyc >= 0) check({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Drives start at a negedge; returns at the next negedge (cycle 1 of the vector).
    task automatic issue_start(input int l, input bit push, input int res, input int ov,
                               input bit chk_cyc, input string name);
        exp_t e;
        e.res  = res;
        e.ovf  = ov;
        e.cyc  = chk_cyc ? (cyc + 1 + 2 * l) : -1;
        e.name = name;
        if (push) sb.push_back(e);
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents a pair and returns at the negedge after it was accepted.
    task automatic send_pair(input int pa, input int pb);
        int n = 0;
        a        = 4'(pa);
        b        = 4'(pb);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("handshake_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit saw_ready);
        int n = 0;
        saw_ready = 1'b0;
        while (busy && n < 200) begin
            saw_ready |= in_ready;
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    initial begin
        bit saw;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_mul_a", int'(mul_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // len=3, continuous valid: 12+225+14 = 251, done at cycle 7
        issue_start(3, 1, 251, 0, 1, "len3");
        send_pair(3, 4);
        send_pair(15, 15);
        send_pair(2, 7);
        in_valid = 1'b0;
        wait_idle(saw);
        check("len3_busy_after", int'(busy), 0);
        check("len3_done_after", int'(done), 0);
        check("len3_result_held", int'(result), 251);
        @(negedge clk);

        // len=0: straight to DONE at cycle 1, never ready
        issue_start(0, 1, 0, 0, 1, "len0");
        wait_idle(saw);
        check("len0_no_ready", int'(saw), 0);
        @(negedge clk);

        // len=2 with a 3-cycle valid gap: 25+36 = 61
        issue_start(2, 1, 61, 0, 0, "stall");
        send_pair(5, 5);
        in_valid = 1'b0;
        a = 4'd9;
        b = 4'd9;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", int'(in_ready), 1);
            check("stall_mul_a_held", int'(mul_a), 5);
            @(negedge clk);
        end
        send_pair(6, 6);
        in_valid = 1'b0;
        wait_idle(saw);
        @(negedge clk);

        // Overflow at ACC_W=8: 225+225 = 450 -> wrap 194, saturate 255
`ifdef MAC_SATURATE_EN
        issue_start(2, 1, 255, 1, 1, "ovf");
`else
        issue_start(2, 1, 194, 1, 1, "ovf");
`endif
        send_pair(15, 15);
        send_pair(15, 15);
        in_valid = 1'b0;
        wait_idle(saw);
        @(negedge clk);

        // len=4 with start and in_valid noise during ACC: 2+12+30+56 = 100
        issue_start(4, 1, 100, 0, 1, "noise");
        for (int i = 0; i < 4; i++) begin
            check("noise_ready_run", int'(in_ready), 1);
            a        = 4'(2 * i + 1);
            b        = 4'(2 * i + 2);
            in_valid = 1'b1;
            @(negedge clk);
            check("noise_ready_acc", int'(in_ready), 0);
            a     = 4'd15;
            b     = 4'd15;
            start = 1'b1;
            len   = LEN_W'(1);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("noise_mul_a_last", int'(mul_a), 7);
        wait_idle(saw);
        @(negedge clk);

        // Reset after 2 of 4 pairs aborts without a done pulse
        issue_start(4, 0, 0, 0, 0, "abort");
        send_pair(2, 3);
        send_pair(4, 5);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        check("abort_mul_a", int'(mul_a), 0);
        check("abort_mul_b", int'(mul_b), 0);
        check("abort_in_ready", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        issue_start(1, 1, 81, 0, 1, "after_abort");
        send_pair(9, 9);
        in_valid = 1'b0;
        wait_idle(saw);
        repeat (2) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
